// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline (pc, if_id, id_ex, ex_mem, mem_wb).
// Optional stall counter enabled by defining PIPE_HAZARD_STALL_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_use_i,
    input  logic              div_start_i,
    input  logic              div_done_i,
    input  logic              jump_req_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              trap_req_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              mem_wait_i,
    output logic [4:0]        hold_en_o,
    output logic [4:0]        flush_o,
    output logic              pc_jump_en_o,
    output logic [ADDR_W-1:0] pc_jump_addr_o,
    output logic              trap_ack_o,
    input  logic              stall_cnt_clr_i,
    output logic [31:0]       stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, DIV_WAIT, TRAP_DRAIN, TRAP_JUMP} state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] taddr_q, taddr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            taddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            taddr_q <= taddr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        taddr_d        = taddr_q;
        hold_en_o      = 5'b00000;
        flush_o        = 5'b00000;
        pc_jump_en_o   = 1'b0;
        pc_jump_addr_o = '0;
        trap_ack_o     = 1'b0;
        if (rst) begin
            state_d = IDLE;
        end else if (mem_wait_i) begin
            // Everything upstream of mem_wb freezes; mem_wb takes a bubble.
            hold_en_o = 5'b01111;
            flush_o   = 5'b10000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_start_i) begin
                        if (!div_done_i) begin
                            hold_en_o = 5'b00111;
                            flush_o   = 5'b01000;
                            state_d   = DIV_WAIT;
                        end
                    end else if (jump_req_i) begin
                        pc_jump_en_o   = 1'b1;
                        pc_jump_addr_o = jump_addr_i;
                        flush_o        = 5'b00110;
                    end else if (trap_req_i) begin
                        taddr_d   = trap_addr_i;
                        cnt_d     = DRAIN_INIT;
                        hold_en_o = 5'b00011;
                        flush_o   = 5'b00100;
                        // The acceptance cycle is itself the first bubble.
                        state_d   = (DRAIN_CYCLES == 1) ? TRAP_JUMP : TRAP_DRAIN;
                    end else if (load_use_i) begin
                        hold_en_o = 5'b00011;
                        flush_o   = 5'b00100;
                    end
                end
                DIV_WAIT: begin
                    if (div_done_i) begin
                        state_d = IDLE;
                    end else begin
                        hold_en_o = 5'b00111;
                        flush_o   = 5'b01000;
                    end
                end
                TRAP_DRAIN: begin
                    hold_en_o = 5'b00011;
                    flush_o   = 5'b00100;
                    cnt_d     = cnt_q - 4'd1;
                    if (cnt_q <= 4'd2) begin
                        state_d = TRAP_JUMP;
                    end
                end
                TRAP_JUMP: begin
                    pc_jump_en_o   = 1'b1;
                    pc_jump_addr_o = taddr_q;
                    flush_o        = 5'b01110;
                    trap_ack_o     = 1'b1;
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_cnt_clr_i) begin
            stall_cnt_q <= '0;
        end else if ((|hold_en_o) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_stall_clr;
    assign unused_stall_clr = stall_cnt_clr_i;
    assign stall_cnt_o      = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected per-cycle outputs are queued when
// stimulus is applied and compared at the following falling edge.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_use_i, div_start_i, div_done_i, jump_req_i, trap_req_i, mem_wait_i;
    logic [31:0] jump_addr_i, trap_addr_i;
    logic [4:0]  hold_en_o, flush_o;
    logic        pc_jump_en_o, trap_ack_o;
    logic [31:0] pc_jump_addr_o;
    logic        stall_cnt_clr_i;
    logic [31:0] stall_cnt_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_cnt = 32'd0;

    typedef struct {
        logic [4:0]  hold;
        logic [4:0]  flush;
        logic        jen;
        logic [31:0] jaddr;
        logic        ack;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.ADDR_W(32), .DRAIN_CYCLES(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_use_i     (load_use_i),
        .div_start_i    (div_start_i),
        .div_done_i     (div_done_i),
        .jump_req_i     (jump_req_i),
        .jump_addr_i    (jump_addr_i),
        .trap_req_i     (trap_req_i),
        .trap_addr_i    (trap_addr_i),
        .mem_wait_i     (mem_wait_i),
        .hold_en_o      (hold_en_o),
        .flush_o        (flush_o),
        .pc_jump_en_o   (pc_jump_en_o),
        .pc_jump_addr_o (pc_jump_addr_o),
        .trap_ack_o     (trap_ack_o),
        .stall_cnt_clr_i(stall_cnt_clr_i),
        .stall_cnt_o    (stall_cnt_o)
    );

    // Queue the expectation for the inputs currently driven, compare at negedge,
    // advance the stall-counter model, then step to just after the next rising edge.
    task automatic expect_cyc(input logic [4:0] eh, input logic [4:0] ef, input logic ej,
                              input logic [31:0] ea, input logic eack, input string tag);
        exp_t e;
        exp_t g;
        e.hold = eh; e.flush = ef; e.jen = ej; e.jaddr = ea; e.ack = eack; e.tag = tag;
`ifdef PIPE_HAZARD_STALL_CNT_EN
        e.cnt = model_cnt;
`else
        e.cnt = 32'd0;
`endif
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        checks++;
        assert (hold_en_o === g.hold) else begin
            errors++;
            $error("FAIL %s hold_en_o got %b exp %b", g.tag, hold_en_o, g.hold);
        end
        checks++;
        assert (flush_o === g.flush) else begin
            errors++;
            $error("FAIL %s flush_o got %b exp %b", g.tag, flush_o, g.flush);
        end
        checks++;
        assert (pc_jump_en_o === g.jen) else begin
            errors++;
            $error("FAIL %s pc_jump_en_o got %b exp %b", g.tag, pc_jump_en_o, g.jen);
        end
        checks++;
        assert (pc_jump_addr_o === g.jaddr) else begin
            errors++;
            $error("FAIL %s pc_jump_addr_o got %h exp %h", g.tag, pc_jump_addr_o, g.jaddr);
        end
        checks++;
        assert (trap_ack_o === g.ack) else begin
            errors++;
            $error("FAIL %s trap_ack_o got %b exp %b", g.tag, trap_ack_o, g.ack);
        end
        checks++;
        assert (stall_cnt_o === g.cnt) else begin
            errors++;
            $error("FAIL %s stall_cnt_o got %0d exp %0d", g.tag, stall_cnt_o, g.cnt);
        end
        if (rst)                                        model_cnt = 32'd0;
        else if (stall_cnt_clr_i)                       model_cnt = 32'd0;
        else if ((|eh) && model_cnt != 32'hFFFF_FFFF)  model_cnt = model_cnt + 32'd1;
        $display("cycle %-12s hold=%b flush=%b jen=%b addr=%h ack=%b cnt=%0d",
                 g.tag, hold_en_o, flush_o, pc_jump_en_o, pc_jump_addr_o, trap_ack_o, stall_cnt_o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        load_use_i = 1'b1; div_start_i = 1'b0; div_done_i = 1'b0;
        jump_req_i = 1'b1; jump_addr_i = 32'h0000_0040;
        trap_req_i = 1'b0; trap_addr_i = 32'h0;
        mem_wait_i = 1'b0; stall_cnt_clr_i = 1'b0;

        // Outputs are forced low while reset is held, regardless of requests.
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "reset");
        rst = 1'b0; load_use_i = 1'b0; jump_req_i = 1'b0;
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "idle");

        load_use_i = 1'b1;
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "load_use");
        load_use_i = 1'b0;
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "lu_after");

        jump_req_i = 1'b1; jump_addr_i = 32'h0000_0100;
        expect_cyc(5'b00000, 5'b00110, 1'b1, 32'h0000_0100, 1'b0, "jump");
        jump_req_i = 1'b0;
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "jump_after");

        // Divide 0..4 with a trap arriving mid-wait; the trap waits for IDLE.
        div_start_i = 1'b1;
        expect_cyc(5'b00111, 5'b01000, 1'b0, 32'h0, 1'b0, "div_c0");
        div_start_i = 1'b0;
        expect_cyc(5'b00111, 5'b01000, 1'b0, 32'h0, 1'b0, "div_c1");
        trap_req_i = 1'b1; trap_addr_i = 32'h0000_0C00;
        expect_cyc(5'b00111, 5'b01000, 1'b0, 32'h0, 1'b0, "div_c2");
        expect_cyc(5'b00111, 5'b01000, 1'b0, 32'h0, 1'b0, "div_c3");
        div_done_i = 1'b1;
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "div_done");
        div_done_i = 1'b0;
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "dtrap_c0");
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "dtrap_c1");
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "dtrap_c2");
        expect_cyc(5'b00000, 5'b01110, 1'b1, 32'h0000_0C00, 1'b1, "dtrap_ack");
        trap_req_i = 1'b0;

        div_start_i = 1'b1; div_done_i = 1'b1;
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "div_fast");
        div_done_i = 1'b0; jump_req_i = 1'b1; jump_addr_i = 32'h0000_0200;
        expect_cyc(5'b00111, 5'b01000, 1'b0, 32'h0, 1'b0, "div_vs_jump");
        div_start_i = 1'b0; jump_req_i = 1'b0; div_done_i = 1'b1;
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "div_vj_done");
        div_done_i = 1'b0;

        // Plain trap; a jump during drain must be ignored.
        trap_req_i = 1'b1; trap_addr_i = 32'h8000_0000;
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "trap_c0");
        jump_req_i = 1'b1; jump_addr_i = 32'h0000_0300;
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "trap_c1");
        jump_req_i = 1'b0;
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "trap_c2");
        expect_cyc(5'b00000, 5'b01110, 1'b1, 32'h8000_0000, 1'b1, "trap_ack");
        trap_req_i = 1'b0;
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "trap_after");

        // Two mem_wait cycles inside the drain delay the ack by exactly two.
        trap_req_i = 1'b1; trap_addr_i = 32'h0000_2000;
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "mwt_c0");
        mem_wait_i = 1'b1;
        expect_cyc(5'b01111, 5'b10000, 1'b0, 32'h0, 1'b0, "mwt_c1");
        expect_cyc(5'b01111, 5'b10000, 1'b0, 32'h0, 1'b0, "mwt_c2");
        mem_wait_i = 1'b0;
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "mwt_c3");
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "mwt_c4");
        expect_cyc(5'b00000, 5'b01110, 1'b1, 32'h0000_2000, 1'b1, "mwt_ack");
        trap_req_i = 1'b0;

        mem_wait_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h0000_0400;
        expect_cyc(5'b01111, 5'b10000, 1'b0, 32'h0, 1'b0, "mw_idle_jmp");
        mem_wait_i = 1'b0; jump_req_i = 1'b0;

        // Reset during drain abandons the trap with no ack afterwards.
        trap_req_i = 1'b1; trap_addr_i = 32'h0000_5000;
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "rtrap_c0");
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "rtrap_c1");
        rst = 1'b1;
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "rtrap_rst");
        rst = 1'b0; trap_req_i = 1'b0;
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "rtrap_p1");
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "rtrap_p2");

        // Stall counter: clear, five stall cycles, read 5 while clearing, then 0.
        load_use_i = 1'b1;
        expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "cnt_pre");
        load_use_i = 1'b0; stall_cnt_clr_i = 1'b1;
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "cnt_clr0");
        stall_cnt_clr_i = 1'b0; load_use_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_cyc(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, "cnt_stall");
        end
        load_use_i = 1'b0; stall_cnt_clr_i = 1'b1;
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "cnt_read5");
        stall_cnt_clr_i = 1'b0;
        expect_cyc(5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0, "cnt_read0");
`ifdef PIPE_HAZARD_STALL_CNT_EN
        checks++;
        assert (model_cnt === 32'd0) else begin
            errors++;
            $error("FAIL cnt_model got %0d exp 0", model_cnt);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
